// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: RV64I funct3 encodings for
// loads and stores, the FSM state type, and the request legality check.
// ----------------------------------------------------------------------------
package lsu_pkg;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // Store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lsu_state_t;

  // Loads accept every encoding except 111; stores only 000..011.
  function automatic logic is_legal(input logic write, input logic [2:0] funct3);
    if (write) return !funct3[2];
    else       return funct3 != 3'b111;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// ----------------------------------------------------------------------------
// lsu_data_align
// Purely combinational lane shaping for a big-endian 64-bit memory lane whose
// most significant byte sits at the request address.
//   i_funct3     : latched funct3 of the request
//   i_lane       : 64-bit memory lane (fresh read data or captured rd_q)
//   i_wdata      : right-justified store data
//   o_load_val   : sign/zero-extended load result taken from the top of the lane
//   o_store_lane : lane to write back, new bytes on top, old bytes below
// ----------------------------------------------------------------------------
module lsu_data_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [2:0]        i_funct3,
  input  logic [DATA_W-1:0] i_lane,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load_val,
  output logic [DATA_W-1:0] o_store_lane
);

  logic signed [7:0]  w_byte_s;
  logic signed [15:0] w_half_s;
  logic signed [31:0] w_word_s;

  assign w_byte_s = $signed(i_lane[63:56]);
  assign w_half_s = $signed(i_lane[63:48]);
  assign w_word_s = $signed(i_lane[63:32]);

  // Size casts of the signed views sign-extend; casts of plain slices zero-extend.
  always_comb begin
    o_load_val = '0;
    case (i_funct3)
      LB:      o_load_val = DATA_W'(w_byte_s);
      LH:      o_load_val = DATA_W'(w_half_s);
      LW:      o_load_val = DATA_W'(w_word_s);
      LD:      o_load_val = i_lane;
      LBU:     o_load_val = DATA_W'(i_lane[63:56]);
      LHU:     o_load_val = DATA_W'(i_lane[63:48]);
      LWU:     o_load_val = DATA_W'(i_lane[63:32]);
      default: o_load_val = '0;
    endcase
  end

  always_comb begin
    o_store_lane = i_wdata;
    case (i_funct3[1:0])
      2'b00:   o_store_lane = {i_wdata[7:0],  i_lane[55:0]};
      2'b01:   o_store_lane = {i_wdata[15:0], i_lane[47:0]};
      2'b10:   o_store_lane = {i_wdata[31:0], i_lane[31:0]};
      default: o_store_lane = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Single-outstanding RV64I load/store initiator in front of a big-endian,
// full-lane-write data memory. Sub-doubleword stores are read-modify-write.
//   clk, rst_n        : clock, synchronous active-low reset
//   req_valid/ready   : request handshake (ready only while IDLE)
//   req_write         : 1 = store, 0 = load
//   req_funct3        : RV64I funct3
//   req_addr          : byte address (MSB of the lane)
//   req_wdata         : right-justified store data
//   resp_valid        : one-cycle completion pulse
//   resp_data         : extended load result (0 for stores/errors), held
//   resp_err          : illegal funct3, held, qualified by resp_valid
//   mem_read/mem_write: memory strobes (never both)
//   endereco          : memory address (0 outside READ/WRITE)
//   write_data        : merged write lane (0 outside WRITE)
//   read_data         : combinational memory read lane
// ----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic              r_write;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd_q;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_err;
  logic [DATA_W-1:0] w_lane;
  logic [DATA_W-1:0] w_load_val;
  logic [DATA_W-1:0] w_store_lane;

  // A load leaves READ straight into DONE, so its result must be extracted
  // from the lane arriving this cycle; later stages use the captured copy.
  assign w_lane = (r_state == READ) ? read_data : r_rd_q;

  lsu_data_align #(.DATA_W(DATA_W)) u_align (
    .i_funct3     (r_funct3),
    .i_lane       (w_lane),
    .i_wdata      (r_wdata),
    .o_load_val   (w_load_val),
    .o_store_lane (w_store_lane)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rd_q      <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == READ) r_rd_q <= read_data;
      // Only the illegal-funct3 path jumps from IDLE directly to DONE.
      if (w_next == DONE) begin
        r_resp_err  <= (r_state == IDLE);
        r_resp_data <= (r_state == READ && !r_write) ? w_load_val : '0;
      end
    end
  end

  // Request capture carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && req_valid) begin
      r_write  <= req_write;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    endereco   = '0;
    write_data = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!is_legal(req_write, req_funct3))      w_next = DONE;
          else if (req_write && req_funct3 == SD)    w_next = WRITE;
          else                                       w_next = READ;
        end
      end
      READ: begin
        mem_read = 1'b1;
        endereco = r_addr;
        w_next   = r_write ? WRITE : DONE;
      end
      WRITE: begin
        // Gated by rst_n so a reset landing on this cycle cannot corrupt memory.
        mem_write  = rst_n;
        endereco   = r_addr;
        write_data = w_store_lane;
        w_next     = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign resp_data = r_resp_data;
  assign resp_err  = r_resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int MSZ = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] endereco;
  logic [63:0] write_data;
  logic [63:0] read_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem[MSZ];      // memory attached to the DUT
  logic [7:0] ref_mem[MSZ];  // reference model memory

  // Expectation for the request in flight
  bit          exp_active = 0;
  bit          manual = 0;
  int          exp_cnt, exp_lat, exp_reads, exp_writes, obs_reads, obs_writes;
  int          last_lat;
  logic [63:0] exp_data, exp_addr, exp_lane;
  logic        exp_err;
  logic [63:0] last_data = 64'd0;
  logic        last_err = 1'b0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .endereco   (endereco),
    .write_data (write_data),
    .read_data  (read_data)
  );

  // Big-endian memory: byte at endereco is the lane MSB; address wraps mod MSZ.
  always_comb begin
    read_data = '0;
    for (int i = 0; i < 8; i++)
      read_data = {read_data[55:0], mem[8'(endereco + 64'(i))]};
  end

  always @(posedge clk) begin
    if (mem_write)
      for (int i = 0; i < 8; i++)
        mem[8'(endereco + 64'(i))] <= write_data[63-8*i -: 8];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic mem_cmp(input string name);
    int bad = 0;
    for (int i = 0; i < MSZ; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(name, 64'(bad), 64'd0);
  endtask

  // Reference model: derives response, latency, strobe counts and write lane
  // from the request alone, updating the model memory for stores.
  task automatic model(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd);
    int n;
    logic [63:0] raw;
    exp_addr = a; exp_data = 64'd0; exp_err = 1'b0; exp_lane = 64'd0;
    exp_reads = 0; exp_writes = 0; obs_reads = 0; obs_writes = 0; exp_cnt = 0;
    n = 1 << f3[1:0];
    if (w ? f3[2] : (f3 == 3'b111)) begin
      exp_err = 1'b1;
      exp_lat = 1;
    end else if (!w) begin
      raw = 64'd0;
      for (int i = 0; i < n; i++) raw = (raw << 8) | 64'(ref_mem[8'(a + 64'(i))]);
      if (!f3[2] && n < 8 && raw[8*n-1]) raw = raw | (~64'd0 << (8*n));
      exp_data = raw;
      exp_lat = 2;
      exp_reads = 1;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[8'(a + 64'(i))] = wd[8*(n-1-i) +: 8];
      for (int i = 0; i < 8; i++) exp_lane = (exp_lane << 8) | 64'(ref_mem[8'(a + 64'(i))]);
      exp_reads  = (n == 8) ? 0 : 1;
      exp_writes = 1;
      exp_lat    = (n == 8) ? 2 : 3;
    end
    exp_active = 1;
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && !manual) begin
      chk("strobe_excl", 64'(mem_read & mem_write), 64'd0);
      if (exp_active) begin
        exp_cnt++;
        if (mem_read)  obs_reads++;
        if (mem_write) obs_writes++;
        if (mem_read || mem_write) chk("endereco", endereco, exp_addr);
        if (mem_write) chk("write_lane", write_data, exp_lane);
        chk("busy_ready", 64'(req_ready), 64'd0);
        chk("resp_valid_timing", 64'(resp_valid), 64'(exp_cnt == exp_lat));
        if (exp_cnt == exp_lat) begin
          chk("resp_data", resp_data, exp_data);
          chk("resp_err", 64'(resp_err), 64'(exp_err));
          chk("n_reads", 64'(obs_reads), 64'(exp_reads));
          chk("n_writes", 64'(obs_writes), 64'(exp_writes));
          last_data  = resp_data;
          last_err   = resp_err;
          last_lat   = exp_cnt;
          exp_active = 0;
        end
      end else begin
        chk("idle_ready", 64'(req_ready), 64'd1);
        chk("idle_valid", 64'(resp_valid), 64'd0);
        chk("idle_mrd", 64'(mem_read), 64'd0);
        chk("idle_mwr", 64'(mem_write), 64'd0);
        chk("idle_addr", endereco, 64'd0);
        chk("idle_wdata", write_data, 64'd0);
        chk("hold_data", resp_data, last_data);
        chk("hold_err", 64'(resp_err), 64'(last_err));
      end
    end
  end

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd);
    int guard = 0;
    @(negedge clk);
    while (!req_ready || exp_active) begin
      // Junk offered while busy must be ignored.
      req_valid  = 1'($urandom_range(0, 1));
      req_write  = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = {$urandom, $urandom};
      req_wdata  = {$urandom, $urandom};
      guard++;
      if (guard > 20) begin
        chk("ready_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    model(w, f3, a, wd);
    guard = 0;
    while (exp_active && guard < 12) begin
      @(posedge clk);
      guard++;
    end
    if (exp_active) begin
      chk("resp_timeout", 64'd0, 64'd1);
      exp_active = 0;
    end
    mem_cmp("mem_state");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    for (int i = 0; i < MSZ; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 7; i++) mem[i] = 8'h00;
    mem[7]  = 8'h08;
    mem[40] = 8'h80;
    mem[41] = 8'hC0;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = mem[i];

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_data", resp_data, 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_mrd", 64'(mem_read), 64'd0);
    chk("rst_mwr", 64'(mem_write), 64'd0);
    chk("rst_addr", endereco, 64'd0);
    chk("rst_wdata", write_data, 64'd0);
    rst_n = 1'b1;

    // Directed cases with hand-computed results
    do_req(1'b0, 3'b011, 64'd0, 64'd0);
    chk("ld0_data", last_data, 64'h8);
    chk("ld0_lat", 64'(last_lat), 64'd2);
    do_req(1'b0, 3'b001, 64'd40, 64'd0);
    chk("lh40", last_data, 64'hFFFF_FFFF_FFFF_80C0);
    do_req(1'b0, 3'b101, 64'd40, 64'd0);
    chk("lhu40", last_data, 64'h0000_0000_0000_80C0);
    do_req(1'b0, 3'b000, 64'd40, 64'd0);
    chk("lb40", last_data, 64'hFFFF_FFFF_FFFF_FF80);
    do_req(1'b0, 3'b100, 64'd40, 64'd0);
    chk("lbu40", last_data, 64'h0000_0000_0000_0080);

    do_req(1'b1, 3'b000, 64'd7, 64'h1234_5678_9ABC_DEAB);
    chk("sb7_lat", 64'(last_lat), 64'd3);
    chk("sb7_data", last_data, 64'd0);
    do_req(1'b0, 3'b011, 64'd0, 64'd0);
    chk("ld0_after_sb", last_data, 64'h0000_0000_0000_00AB);

    do_req(1'b1, 3'b011, 64'd24, 64'h0123_4567_89AB_CDEF);
    chk("sd24_lat", 64'(last_lat), 64'd2);
    chk("sd24_b24", 64'(mem[24]), 64'h01);
    chk("sd24_b31", 64'(mem[31]), 64'hEF);
    do_req(1'b0, 3'b010, 64'd24, 64'd0);
    chk("lw24", last_data, 64'h0000_0000_0123_4567);

    do_req(1'b0, 3'b111, 64'd16, 64'd0);
    chk("ld_ill_err", 64'(last_err), 64'd1);
    chk("ld_ill_data", last_data, 64'd0);
    chk("ld_ill_lat", 64'(last_lat), 64'd1);
    do_req(1'b1, 3'b100, 64'd16, 64'hFFFF);
    chk("st_ill_err", 64'(last_err), 64'd1);
    chk("st_ill_lat", 64'(last_lat), 64'd1);

    // Reset landing on the WRITE cycle of an SW
    manual = 1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 64'd100; req_wdata = 64'hCAFE_F00D_DEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_gate", 64'(mem_write), 64'd0);
    chk("rstw_addr", endereco, 64'd100);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstw_ready", 64'(req_ready), 64'd1);
    chk("rstw_valid", 64'(resp_valid), 64'd0);
    mem_cmp("rstw_mem");
    last_data = 64'd0;
    last_err  = 1'b0;
    manual = 0;

    // Randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      a = 64'($urandom_range(0, MSZ - 1));
      if ($urandom_range(0, 3) == 0) a = {$urandom, $urandom};
      do_req(1'($urandom), 3'($urandom), a, {$urandom, $urandom});
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
